// File: rtl/calc_pipe.sv
// calc_pipe: parametrised register-file calculator with an execute/writeback pipeline, forwarding and ZNCV flags
module calc_pipe #(
  parameter int WIDTH = 4,
  parameter int NREGS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [2:0]               control,
  input  logic [$clog2(NREGS)-1:0] src_a,
  input  logic                     b_sel,
  input  logic [$clog2(NREGS)-1:0] src_b,
  input  logic [WIDTH-1:0]         immediate,
  input  logic                     we_en,
  input  logic [$clog2(NREGS)-1:0] we_addr,
  input  logic [$clog2(NREGS)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data,
  output logic [WIDTH-1:0]         res,
  output logic                     res_valid,
  output logic [3:0]               flags
);
  localparam int AW = $clog2(NREGS);
  logic [WIDTH-1:0] regs [NREGS];
  logic             wb_we;
  logic [AW-1:0]    wb_addr;
  logic [WIDTH-1:0] wb_res;
  logic [3:0]       wb_flags;
  logic [WIDTH-1:0] a, rb, b, bx, y;
  logic [WIDTH:0]   sum;
  logic             arith, ovf, lt;
  // a pending WB record is exactly the cycle res_valid is high
  assign a = (res_valid && wb_we && wb_addr == src_a) ? wb_res : regs[src_a];
  assign rb = (res_valid && wb_we && wb_addr == src_b) ? wb_res : regs[src_b];
  assign b = b_sel ? rb : immediate;
  // control[2] inverts B: serves AND_NOT/OR_NOT and turns ADD into SUB with carry-in 1
  assign bx = control[2] ? ~b : b;
  assign sum = {1'b0, a} + {1'b0, bx} + (WIDTH+1)'(control[2]);
  assign arith = control[1:0] == 2'b10;
  assign ovf = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  assign lt = control[2] ? ($signed(a) < $signed(b)) : (a < b);
  assign y = control[1] ? (control[0] ? WIDTH'(lt) : sum[WIDTH-1:0])
                        : (control[0] ? (a | bx) : (a & bx));
  assign rd_data = regs[rd_addr];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      res       <= '0;
      res_valid <= 1'b0;
      flags     <= '0;
      wb_we     <= 1'b0;
      wb_addr   <= '0;
      wb_res    <= '0;
      wb_flags  <= '0;
    end else begin
      res_valid <= in_valid;
      if (in_valid) begin
        res      <= y;
        wb_res   <= y;
        wb_we    <= we_en;
        wb_addr  <= we_addr;
        wb_flags <= {y == '0, y[WIDTH-1], arith & sum[WIDTH], arith & ovf};
      end
      if (res_valid) begin
        flags <= wb_flags;
        if (wb_we) regs[wb_addr] <= wb_res;
      end
    end
  end
endmodule

// File: doc/calc_pipe.md
Name: calc_pipe

Overview:
- Parametrised successor to the 4-bit register-file calculator: NREGS x WIDTH register file, ALU and status flags, in a 2-stage pipeline (execute, writeback).
- Adds the following over the fixed 4x4 calculator:
  - explicit source-A address;
  - register-or-immediate B operand;
  - issue valid and write enable;
  - result forwarding;
  - ZNCV flags.
- Sits between the instruction sequencer (or a testbench) and downstream result consumers. The debug read port retains the original rd_addr/rd_data behaviour.

Parameters:
- WIDTH, 4, datapath, register and immediate width (>=2).
- NREGS, 4, number of registers (power of 2, >=2). Address width AW = clog2(NREGS) is a derived localparam.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction issue strobe; one instruction per cycle, no backpressure
- control  in  3  op: 000 AND, 001 OR, 010 ADD, 011 SLTU, 100 AND_NOT_B, 101 OR_NOT_B, 110 SUB, 111 SLT (signed)
- src_a  in  AW  register address of operand A
- b_sel  in  1  0: B = immediate, 1: B = reg[src_b]
- src_b  in  AW  register address of operand B
- immediate  in  WIDTH  immediate operand B
- we_en  in  1  1: write result to reg[we_addr]; 0: compare-only (flags still update)
- we_addr  in  AW  destination register
- rd_addr  in  AW  debug read address
- rd_data  out  WIDTH  combinational reg[rd_addr]; shows committed state only
- res  out  WIDTH  registered ALU result of the last issued instruction
- res_valid  out  1  high for exactly one cycle, the cycle after issue
- flags  out  4  {Z,N,C,V}, committed at writeback

Behaviour:
- Reset (rst_n low, asynchronous):
  - all registers, res, res_valid, flags and pipeline state clear to 0;
  - any pending writeback is discarded;
  - deassertion is synchronous-safe; the first issue is accepted on the first rising edge with rst_n high.
- Stage EX, at the edge with in_valid=1:
  - read operands with forwarding applied;
  - compute the result;
  - capture res, the WB record (result, we_en, we_addr, flags) and set res_valid=1.
- Stage WB, the next edge:
  - if we_en, write reg[we_addr];
  - load flags.
  - Total latency: issue edge N -> res visible after N; rd_data and flags reflect it after edge N+1.
- in_valid=0 at an edge: res_valid goes 0; res holds its last value; nothing is written.
- Forwarding:
  - if a WB record is pending with we_en=1 and we_addr == src_a (or src_b when b_sel=1), EX uses the WB result instead of the register file.
  - Back-to-back dependent instructions therefore see the newest value.
  - Forwarding priority: WB record over the register file.
- Arithmetic:
  - all results are WIDTH bits; the carry-out is dropped from the result;
  - ADD: C = carry-out; V = signed overflow;
  - SUB: result = a + ~b + 1; C = 1 when there is no borrow (a >= b unsigned); V = signed overflow;
  - SLT: result 1 if a < b signed, else 0, zero-extended; SLTU: same, unsigned;
  - logic ops, SLT and SLTU: C = 0, V = 0;
  - Z = (result == 0); N = result[WIDTH-1], for all ops.
- Simultaneous WB write and rd_addr read of the same register: rd_data shows the old value until the edge, then the new value. There is no combinational bypass on the debug port.
- Destination equal to a source: legal; the operand uses the pre-instruction (or forwarded) value.
- Reset during a pending WB: the write is lost; registers remain 0.

Test Plan:
- Reset check: pulse rst_n low mid-cycle, no clock edge -> res=0, res_valid=0, flags=0000, rd_data=0 for all rd_addr 0..3.
- Back-to-back r0 chain, b_sel=0, src_a=we_addr=0, issued on consecutive cycles:
  - AND 1010 -> res 0000, Z=1;
  - OR 0101 -> res 0101 (forwarded);
  - ADD 0011 -> res 1000, flags Z0 N1 C0 V1;
  - after one idle cycle, rd_data(r0) = 1000.
- SUB with register source: r1 = r0 - 0010, with r0 = 1000 -> r1 = 0110, C=1, V=1, N=0.
- Next, r2 = r0 + r0 (b_sel=1) -> 0000, C=1, V=1, Z=1.
- ADD wrap: r0 = 1000 + imm 1111 -> 0111, C=1, V=1.
- SLT vs SLTU, r0 = 1000, imm 0001, we_en=0:
  - SLT -> res 0001;
  - SLTU -> res 0000, Z=1;
  - r0 unchanged (1000).
- Reset mid-op: issue ADD r3 = r3 + 0101, then drop rst_n before the WB edge -> r3 = 0, res_valid = 0, flags = 0000.
- Repeat the ADD chain with WIDTH=8, NREGS=8 -> 0x80 + 0xFF = 0x7F, C=1, V=1.
